// File: rtl/fifo_fwft_reader.sv
`timescale 1ns/1ps
// Read-side adapter for the async FIFO: prefetches words into a small skid
// buffer and presents them as a first-word-fall-through valid/ready stream.
module fifo_fwft_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
  input  logic                       flush,
  output logic                       m_valid,
  output logic [DATA_WIDTH-1:0]      m_data,
  input  logic                       m_ready,
  output logic [$clog2(BUF_DEPTH):0] buf_count
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(RD_LATENCY + 1);
  localparam int SW = CW + 1;

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [RD_LATENCY-1:0] sr_q, sr_d;
  logic [IW-1:0]         infl_q, infl_d;
  logic                  run_q, run_d;
  logic [SW-1:0]         credit_sum;
  logic                  rd_en;
  logic                  arrive;
  logic                  pop;

  always_comb begin
    credit_sum = SW'(count_q) + SW'(infl_q);
    // Credit is taken from registered occupancy only; a pop this cycle frees nothing yet.
    rd_en  = run_q & ~fifo_empty & ~flush & (credit_sum < SW'(BUF_DEPTH));
    arrive = sr_q[RD_LATENCY-1];
    pop    = (count_q != '0) & m_ready;

    run_d    = 1'b1;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(arrive) - CW'(pop);
    infl_d   = infl_q + IW'(rd_en) - IW'(arrive);
    sr_d     = RD_LATENCY'({sr_q, rd_en});

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (arrive && !flush) begin
      mem_d[wr_ptr_q] = fifo_rd_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    // Clearing the in-flight bits is what keeps late words out after a flush.
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      infl_d   = '0;
      sr_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      infl_q   <= '0;
      sr_q     <= '0;
    end else begin
      run_q    <= run_d;
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      infl_q   <= infl_d;
      sr_q     <= sr_d;
    end
  end

  assign fifo_rd_en = rd_en;
  assign m_valid    = (count_q != '0);
  assign m_data     = mem_q[rd_ptr_q];
  assign buf_count  = count_q;

endmodule

// File: tb/tb_fifo_fwft_reader.sv
`timescale 1ns/1ps
// Bench for fifo_fwft_reader: two instances (read latency 1 and 2) share one
// stimulus stream; each has its own upstream FIFO model and scoreboard.
module tb_fifo_fwft_reader;

  localparam int DW   = 16;
  localparam int BD   = 4;
  localparam int FMEM = 16384;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          flush      = 1'b0;
  logic          m_ready    = 1'b0;
  logic          hold_empty = 1'b0;
  logic [DW-1:0] fmem [FMEM];
  int            fwr        = 0;
  int            n_checks   = 0;
  int            n_fail     = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : ln
    localparam int LAT = g + 1;
    logic                fifo_empty;
    logic                fifo_rd_en;
    logic [DW-1:0]       fifo_rd_data;
    logic                m_valid;
    logic [DW-1:0]       m_data;
    logic [$clog2(BD):0] buf_count;
    logic [DW-1:0]       rd_pipe [LAT];
    int                  frd = 0;
    logic [DW-1:0]       exp_q[$];
    logic                prev_stall = 1'b0;
    logic [DW-1:0]       prev_data  = '0;

    assign fifo_empty   = hold_empty | (frd == fwr);
    assign fifo_rd_data = rd_pipe[LAT-1];

    fifo_fwft_reader #(
      .DATA_WIDTH(DW),
      .RD_LATENCY(LAT),
      .BUF_DEPTH (BD)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fifo_empty  (fifo_empty),
      .fifo_rd_en  (fifo_rd_en),
      .fifo_rd_data(fifo_rd_data),
      .flush       (flush),
      .m_valid     (m_valid),
      .m_data      (m_data),
      .m_ready     (m_ready),
      .buf_count   (buf_count)
    );

    // Upstream FIFO: data appears LAT cycles after an accepted read, junk otherwise.
    always @(posedge clk) begin
      rd_pipe[0] <= fifo_rd_en ? fmem[frd[13:0]] : 16'hDEAD;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (fifo_rd_en) frd <= frd + 1;
    end

    // Scoreboard: a word read from the FIFO is owed to the stream until delivered or dropped.
    always @(negedge clk) begin
      if (!rst_n) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        check_eq($sformatf("L%0d_rd_while_empty", LAT), 32'(fifo_rd_en & fifo_empty), 0);
        check_eq($sformatf("L%0d_no_overflow", LAT), 32'(exp_q.size() <= BD), 1);
        check_eq($sformatf("L%0d_count_le_owed", LAT), 32'(int'(buf_count) <= exp_q.size()), 1);
        if (flush) check_eq($sformatf("L%0d_rd_in_flush", LAT), 32'(fifo_rd_en), 0);
        if (prev_stall && m_valid)
          check_eq($sformatf("L%0d_stall_stable", LAT), 32'(m_data), 32'(prev_data));
        if (m_valid && m_ready) begin
          check_eq($sformatf("L%0d_sb_has_word", LAT), 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0)
            check_eq($sformatf("L%0d_sb_data", LAT), 32'(m_data), 32'(exp_q.pop_front()));
        end
        if (fifo_rd_en) exp_q.push_back(fmem[frd[13:0]]);
        if (flush) exp_q.delete();
        prev_stall = m_valid & ~m_ready & ~flush;
        prev_data  = m_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fmem[fwr[13:0]] = w;
    fwr++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rden0"},  32'(ln[0].fifo_rd_en), 0);
    check_eq({tag, "_valid0"}, 32'(ln[0].m_valid), 0);
    check_eq({tag, "_data0"},  32'(ln[0].m_data), 0);
    check_eq({tag, "_count0"}, 32'(ln[0].buf_count), 0);
    check_eq({tag, "_rden1"},  32'(ln[1].fifo_rd_en), 0);
    check_eq({tag, "_valid1"}, 32'(ln[1].m_valid), 0);
    check_eq({tag, "_data1"},  32'(ln[1].m_data), 0);
    check_eq({tag, "_count1"}, 32'(ln[1].buf_count), 0);
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    m_ready    = 1'b1;
    flush      = 1'b0;
    hold_empty = 1'b0;
    while (c < 4000 && !(ln[0].exp_q.size() == 0 && ln[1].exp_q.size() == 0 &&
                         ln[0].frd == fwr && ln[1].frd == fwr)) begin
      step();
      c++;
    end
    check_eq({tag, "_done"}, 32'(c < 4000), 1);
    check_eq({tag, "_idle0"}, 32'(ln[0].m_valid), 0);
    check_eq({tag, "_idle1"}, 32'(ln[1].m_valid), 0);
  endtask

  // Watch the first word of each instance after an event and compare it with want.
  task automatic first_word(input string tag, input logic [DW-1:0] want);
    logic [DW-1:0] got [2];
    logic          seen [2];
    got  = '{default: '0};
    seen = '{default: 1'b0};
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!seen[0] && ln[0].m_valid) begin seen[0] = 1'b1; got[0] = ln[0].m_data; end
      if (!seen[1] && ln[1].m_valid) begin seen[1] = 1'b1; got[1] = ln[1].m_data; end
    end
    check_eq({tag, "_L1"}, 32'(got[0]), 32'(want));
    check_eq({tag, "_L2"}, 32'(got[1]), 32'(want));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n_rd0;
    int            n_rd1;
    logic [DW-1:0] word;

    // Reset release with three words already queued.
    for (int i = 0; i < 3; i++) push_word(16'hA001 + 16'(i));
    m_ready = 1'b1;
    #2;
    check_reset_outputs("rst");
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_eq($sformatf("t1_rden_c%0d", c), 32'(ln[0].fifo_rd_en), 32'(c >= 1 && c <= 3));
      check_eq($sformatf("t1_valid_c%0d", c), 32'(ln[0].m_valid), 32'(c >= 3 && c <= 5));
      if (c >= 3 && c <= 5)
        check_eq($sformatf("t1_data_c%0d", c), 32'(ln[0].m_data), 32'(16'hA001 + c - 3));
      check_eq($sformatf("t1_valid_l2_c%0d", c), 32'(ln[1].m_valid), 32'(c >= 4 && c <= 6));
    end

    // Back-pressure: ten words, downstream stalled.
    step();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word(16'hB000 + 16'(i));
    n_rd0 = 0;
    n_rd1 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_rd0 += int'(ln[0].fifo_rd_en);
      n_rd1 += int'(ln[1].fifo_rd_en);
    end
    check_eq("bp_reads_L1", n_rd0, 4);
    check_eq("bp_reads_L2", n_rd1, 4);
    check_eq("bp_count_L1", 32'(ln[0].buf_count), 4);
    check_eq("bp_count_L2", 32'(ln[1].buf_count), 4);
    check_eq("bp_head_L1", 32'(ln[0].m_data), 32'h0000B000);
    check_eq("bp_head_L2", 32'(ln[1].m_data), 32'h0000B000);
    step();
    m_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      check_eq($sformatf("bp_run_L1_c%0d", c), 32'(ln[0].m_valid), 32'(c < 10));
      check_eq($sformatf("bp_run_L2_c%0d", c), 32'(ln[1].m_valid), 32'(c < 10));
    end

    // Streaming 64 words with the downstream always ready.
    step();
    for (int i = 0; i < 64; i++) push_word(16'hC000 + 16'(i));
    for (int c = 0; c < 72; c++) begin
      @(negedge clk);
      check_eq($sformatf("st_L1_c%0d", c), 32'(ln[0].m_valid), 32'(c >= 2 && c < 66));
      check_eq($sformatf("st_L2_c%0d", c), 32'(ln[1].m_valid), 32'(c >= 3 && c < 67));
    end

    // Flush with three words buffered and one in flight (latency-1 instance).
    step();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word(16'hD000 + 16'(i));
    repeat (4) step();
    check_eq("fl_pre_count_L1", 32'(ln[0].buf_count), 3);
    check_eq("fl_pre_owed_L1", 32'(ln[0].exp_q.size()), 4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("fl_valid_L1", 32'(ln[0].m_valid), 0);
    check_eq("fl_count_L1", 32'(ln[0].buf_count), 0);
    check_eq("fl_valid_L2", 32'(ln[1].m_valid), 0);
    check_eq("fl_count_L2", 32'(ln[1].buf_count), 0);
    m_ready = 1'b1;
    first_word("fl_next", 16'hD004);
    drain("fl_drain");

    // Random ready, empty gating and occasional flush.
    word = 16'hE000;
    for (int c = 0; c < 10000; c++) begin
      m_ready    = 1'($urandom_range(0, 1));
      hold_empty = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) < 3) begin
        push_word(word);
        word++;
      end
      step();
    end
    drain("rand_drain");

    // Reset mid-stream with two buffered and one in flight (latency-1 instance).
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(16'hF000 + 16'(i));
    repeat (3) step();
    check_eq("mr_pre_count_L1", 32'(ln[0].buf_count), 2);
    check_eq("mr_pre_owed_L1", 32'(ln[0].exp_q.size()), 3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mr");
    step();
    step();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    first_word("mr_next", 16'hF003);
    drain("mr_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_fwft_reader.md
# fifo_fwft_reader

Read-side stage placed directly downstream of the team's asynchronous FIFO, in the FIFO read clock domain. It converts the FIFO's registered-output rd_en/empty interface into a first-word-fall-through valid/ready stream. Read requests are issued ahead of demand, and returning words go into a small local skid buffer, so the stream sustains one word per cycle under back-pressure. Flush discards buffered and in-flight words.

## Interface
- DATA_WIDTH, 16, word width; must match the upstream FIFO.
- RD_LATENCY, 1, cycles from fifo_rd_en to fifo_rd_data valid; legal values are 1 and 2.
- BUF_DEPTH, 4, skid buffer entries; power of two; must be >= RD_LATENCY+2.

- clk  in  1  clock; same clock as the upstream FIFO's read clock.
- rst_n  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  upstream FIFO empty flag.
- fifo_rd_en  out  1  read request to the upstream FIFO.
- fifo_rd_data  in  DATA_WIDTH  upstream read data, valid RD_LATENCY cycles after an accepted read.
- flush  in  1  synchronous discard of all buffered and in-flight words.
- m_valid  out  1  stream word available.
- m_data  out  DATA_WIDTH  stream word; this is the buffer head.
- m_ready  in  1  downstream accept.
- buf_count  out  $clog2(BUF_DEPTH)+1  number of words held in the buffer; excludes in-flight reads.

## Operation
- Internal state:
  - circular buffer, BUF_DEPTH x DATA_WIDTH, with read pointer, write pointer and count;
  - in-flight shift register, RD_LATENCY bits, bit 0 = issued this cycle;
  - inflight count, 0..RD_LATENCY;
  - run flag.
- Run flag: resets to 0 and is set to 1 on the first clk edge after rst_n deasserts. fifo_rd_en is 0 whenever the run flag is 0.
- Issue rule (combinational): fifo_rd_en = run & ~fifo_empty & ~flush & (buf_count + inflight < BUF_DEPTH).
  - The credit check uses registered values only. A pop in the same cycle gives no credit.
- Every cycle:
  - the in-flight shift register shifts, taking fifo_rd_en as its new bit;
  - when the bit leaving the register is 1, fifo_rd_data is written at the write pointer in that cycle.
- Overflow is impossible by construction. The verification bench asserts that the buffer never overflows.
- Pop: occurs when m_valid & m_ready. The read pointer advances.
- Pointers wrap modulo BUF_DEPTH.
- buf_count next value = buf_count + arrive - pop. A simultaneous arrive and pop leaves the count unchanged.
- m_valid = (buf_count != 0). m_data = the entry at the read pointer. Both are registered-state driven, with no combinational path from m_ready.
- Flush:
  - a handshake in the flush cycle still completes, and the downstream keeps that word;
  - at the next edge, count, pointers, inflight and the shift register all clear;
  - a word that arrives in the flush cycle is dropped;
  - fifo_rd_en is 0 during the flush cycle;
  - words arriving after flush are never written, because their in-flight bits were cleared.
- No state machine beyond the run flag. The block is purely counter- and pointer-based.

## Timing
- Reset values:
  - fifo_rd_en = 0;
  - m_valid = 0;
  - m_data = 0, with buffer entries cleared;
  - buf_count = 0;
  - run = 0.
- Reset asserted mid-operation drops all buffered and in-flight words immediately. Late FIFO data is ignored.
- Latency: with fifo_rd_en high in cycle T, fifo_rd_data is captured at the end of cycle T+RD_LATENCY, and m_valid is 1 in cycle T+RD_LATENCY+1.
- First word after reset, with the FIFO already non-empty: the run flag is set at edge 1, fifo_rd_en is high in cycle 1, and m_valid rises in cycle 2+RD_LATENCY.
- Throughput: one word per cycle sustained when m_ready = 1 and the FIFO is non-empty. This requires BUF_DEPTH >= RD_LATENCY+2.
- Back-pressure: with m_ready held at 0, at most BUF_DEPTH - inflight further reads are issued, after which fifo_rd_en = 0. When m_ready returns to 1, the stall-free restart takes one pop per cycle.
- FIFO goes empty: issue stops in that same cycle. Buffered words still drain.
- m_data is stable while m_valid & ~m_ready.
- flush and m_ready asserted together: the handshake completes, then flush applies; m_valid = 0 next cycle.

## Test plan
- Reset release with 3 words (0xA001..0xA003) pre-loaded, m_ready = 1, RD_LATENCY = 1 -> fifo_rd_en high in cycles 1-3; m_valid is high in cycles 3-5 carrying 0xA001, 0xA002, 0xA003 in order.
- Back-pressure: 10 words queued, m_ready = 0 -> fifo_rd_en issues exactly 4 times, buf_count settles at 4, m_data = first word stable. When m_ready = 1, all 10 words are delivered in order with no gaps after the first.
- Streaming: 64 words, m_ready = 1, RD_LATENCY = 2, BUF_DEPTH = 4 -> 64 consecutive cycles with m_valid = 1 after the initial 3-cycle latency; data order preserved.
- Flush with buf_count = 3 and 1 word in flight -> m_valid = 0 the next cycle, buf_count = 0, and the in-flight word never appears. The next FIFO word is the next delivered.
- Random m_ready (50%) and random fifo_empty over 10k cycles -> scoreboard shows no loss, duplication or reordering; buf_count + inflight <= BUF_DEPTH always; no fifo_rd_en while fifo_empty = 1.
- rst_n pulsed low mid-stream with 2 buffered words and 1 in flight -> all outputs return to their reset values immediately, and the late-arriving FIFO word is not delivered.
